// File: rtl/composition_recorder_pkg.sv
// Shared types and sizing for the melody recorder that feeds the playback decoder.
package composition_pkg;

    localparam int MAX_NOTES = 40;
    localparam int NOTE_W    = 6;
    localparam int IDX_W     = 6;

    typedef logic [NOTE_W-1:0] note_t;

    typedef enum logic {
        S_EDIT = 1'b0,
        S_PLAY = 1'b1
    } rec_state_t;

endpackage

// File: rtl/composition_recorder_rise_detect.sv
// Single-cycle rising-edge pulse for an already synchronised, debounced button level.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/composition_recorder.sv
// Records button-entered note codes into a fixed array and toggles edit/play for the decoder.
module composition_recorder
    import composition_pkg::*;
#(
    parameter int MAX_NOTES = composition_pkg::MAX_NOTES,
    parameter int IDX_W     = composition_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  note_t            note_in,
    input  logic             add_btn,
    input  logic             undo_btn,
    input  logic             clear_btn,
    input  logic             play_btn,
    output note_t            note_RAM [MAX_NOTES-1:0],
    output logic [IDX_W-1:0] i_note,
    output logic             write_en,
    output logic             full
);

    logic add_rise;
    logic undo_rise;
    logic clear_rise;
    logic play_rise;

    rise_detect u_add_rise (
        .clk   (clk),
        .reset (reset),
        .in    (add_btn),
        .rise  (add_rise)
    );

    rise_detect u_undo_rise (
        .clk   (clk),
        .reset (reset),
        .in    (undo_btn),
        .rise  (undo_rise)
    );

    rise_detect u_clear_rise (
        .clk   (clk),
        .reset (reset),
        .in    (clear_btn),
        .rise  (clear_rise)
    );

    rise_detect u_play_rise (
        .clk   (clk),
        .reset (reset),
        .in    (play_btn),
        .rise  (play_rise)
    );

    rec_state_t state;
    rec_state_t state_next;
    logic       has_notes;
    logic       do_clear;
    logic       do_undo;
    logic       do_append;

    assign full      = (i_note == IDX_W'(MAX_NOTES));
    assign has_notes = (i_note != '0);

    // One edit per cycle (clear > undo > append); the play decision uses the pre-edit count.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_undo    = 1'b0;
        do_append  = 1'b0;
        case (state)
            S_EDIT: begin
                if (clear_rise) begin
                    do_clear = 1'b1;
                end else if (undo_rise) begin
                    do_undo = has_notes;
                end else if (add_rise) begin
                    do_append = ~full;
                end
                if (play_rise && has_notes) begin
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (play_rise) begin
                    state_next = S_EDIT;
                end
            end
            default: begin
                state_next = S_EDIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_EDIT;
            write_en <= 1'b0;
        end else begin
            state    <= state_next;
            write_en <= (state_next == S_PLAY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_note <= '0;
        end else if (do_clear) begin
            i_note <= '0;
        end else if (do_undo) begin
            i_note <= i_note - 1'b1;
        end else if (do_append) begin
            i_note <= i_note + 1'b1;
        end
    end

    // Removed slots are zeroed so everything at or above i_note always reads as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_NOTES; i++) begin
                note_RAM[i] <= '0;
            end
        end else if (do_clear) begin
            for (int i = 0; i < MAX_NOTES; i++) begin
                note_RAM[i] <= '0;
            end
        end else if (do_undo) begin
            note_RAM[i_note - 1'b1] <= '0;
        end else if (do_append) begin
            note_RAM[i_note] <= note_in;
        end
    end

endmodule

// File: tb/tb_composition_recorder.sv
// Randomised and directed scoreboard bench for composition_recorder against a queue-based melody model.
module tb_composition_recorder;

    localparam int N = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] note_in = '0;
    logic       add_btn = 1'b0;
    logic       undo_btn = 1'b0;
    logic       clear_btn = 1'b0;
    logic       play_btn = 1'b0;
    logic [5:0] note_ram [N-1:0];
    logic [5:0] i_note;
    logic       write_en;
    logic       full;

    always #5 clk = ~clk;

    composition_recorder dut (
        .clk       (clk),
        .reset     (reset),
        .note_in   (note_in),
        .add_btn   (add_btn),
        .undo_btn  (undo_btn),
        .clear_btn (clear_btn),
        .play_btn  (play_btn),
        .note_RAM  (note_ram),
        .i_note    (i_note),
        .write_en  (write_en),
        .full      (full)
    );

    typedef struct packed {
        logic [5:0]     n;
        logic           we;
        logic           full;
        logic [N*6-1:0] ram;
    } exp_t;

    exp_t expq[$];
    int   notes[$];
    bit   playing;
    bit   p_add, p_undo, p_clear, p_play;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [N*6-1:0] act, input logic [N*6-1:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [N*6-1:0] model_ram();
        logic [N*6-1:0] r;
        r = '0;
        for (int i = 0; i < notes.size(); i++) r[i*6 +: 6] = 6'(notes[i]);
        return r;
    endfunction

    function automatic logic [N*6-1:0] dut_ram();
        logic [N*6-1:0] r;
        for (int i = 0; i < N; i++) r[i*6 +: 6] = note_ram[i];
        return r;
    endfunction

    task automatic step(input bit a, input bit u, input bit c, input bit p, input logic [5:0] nt);
        bit   ra, ru, rc, rp;
        int   pre_n;
        exp_t e;
        @(negedge clk);
        add_btn = a; undo_btn = u; clear_btn = c; play_btn = p; note_in = nt;
        ra = a & ~p_add; ru = u & ~p_undo; rc = c & ~p_clear; rp = p & ~p_play;
        p_add = a; p_undo = u; p_clear = c; p_play = p;
        pre_n = notes.size();
        if (!playing) begin
            if (rc) notes.delete();
            else if (ru) begin
                if (notes.size() > 0) void'(notes.pop_back());
            end else if (ra && notes.size() < N) notes.push_back(int'(nt));
        end
        if (rp) begin
            if (playing) playing = 1'b0;
            else if (pre_n != 0) playing = 1'b1;
        end
        e.n = 6'(notes.size());
        e.we = playing;
        e.full = (notes.size() == N);
        e.ram = model_ram();
        expq.push_back(e);
    endtask

    task automatic press(input bit a, input bit u, input bit c, input bit p, input logic [5:0] nt);
        step(a, u, c, p, nt);
        step(1'b0, 1'b0, 1'b0, 1'b0, nt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("i_note", N*6'(i_note), N*6'(e.n));
                chk("write_en", N*6'(write_en), N*6'(e.we));
                chk("full", N*6'(full), N*6'(e.full));
                chk("note_RAM", dut_ram(), e.ram);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        playing = 1'b0;
        p_add = 0; p_undo = 0; p_clear = 0; p_play = 0;

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk("reset_i_note", N*6'(i_note), '0);
        chk("reset_write_en", N*6'(write_en), '0);
        chk("reset_full", N*6'(full), '0);
        chk("reset_ram", dut_ram(), '0);
        @(negedge clk); reset = 1'b0;

        // Three single presses.
        press(1, 0, 0, 0, 6'd5);
        press(1, 0, 0, 0, 6'd17);
        press(1, 0, 0, 0, 6'd63);

        // Holding add gives one append.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 6'd9);
        step(0, 0, 0, 0, 6'd9);

        // Fill past capacity, then undo once.
        press(0, 0, 1, 0, 6'd0);
        for (int i = 0; i < 41; i++) press(1, 0, 0, 0, 6'($urandom_range(63, 0)));
        press(0, 1, 0, 0, 6'd0);

        // Undo on empty; clear beats a simultaneous add.
        press(0, 0, 1, 0, 6'd0);
        press(0, 1, 0, 0, 6'd0);
        for (int i = 0; i < 4; i++) press(1, 0, 0, 0, 6'(i + 20));
        press(1, 0, 1, 0, 6'd33);

        // Play handling and frozen edits during playback.
        press(0, 0, 0, 1, 6'd0);
        press(1, 0, 0, 0, 6'd12);
        press(0, 0, 0, 1, 6'd0);
        press(1, 0, 0, 0, 6'd40);
        press(0, 1, 0, 0, 6'd0);
        press(0, 0, 1, 0, 6'd0);
        press(0, 0, 0, 1, 6'd0);

        // Asynchronous reset during playback.
        press(0, 0, 1, 0, 6'd0);
        press(1, 0, 0, 0, 6'd1);
        press(1, 0, 0, 0, 6'd2);
        press(1, 0, 0, 0, 6'd3);
        press(0, 0, 0, 1, 6'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_reset_write_en", N*6'(write_en), '0);
        chk("async_reset_i_note", N*6'(i_note), '0);
        chk("async_reset_ram", dut_ram(), '0);
        notes.delete();
        playing = 1'b0;
        p_add = 0; p_undo = 0; p_clear = 0; p_play = 0;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        press(0, 0, 0, 1, 6'd0);
        press(1, 0, 0, 0, 6'd7);
        press(0, 0, 0, 1, 6'd0);
        press(0, 0, 0, 1, 6'd0);

        // Random button traffic, including coincident rises.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99, 0) < 40, $urandom_range(99, 0) < 15,
                 $urandom_range(99, 0) < 4, $urandom_range(99, 0) < 8,
                 6'($urandom_range(63, 0)));
        end

        @(posedge clk); #2;
        chk("scoreboard_drained", N*6'(expq.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/composition_recorder.md
Name: composition_recorder

Overview:
- Upstream neighbour of the audio playback decoder.
- Captures a user-entered melody, one 6-bit note code (0 = C2 … 63 = D#7) per button press, into a 40-entry note array.
- Maintains the placed-note count and drives the playback enable.
- Its note_RAM, i_note and write_en outputs connect directly to the decoder's inputs of the same names.

Parameters:
- MAX_NOTES, 40, capacity of the note array; valid indices 0..MAX_NOTES-1.
- IDX_W, 6, width of i_note; must satisfy 2^IDX_W > MAX_NOTES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- note_in  input  6  note code to append; sampled on an accepted append.
- add_btn  input  1  level; its rising edge requests an append.
- undo_btn  input  1  level; its rising edge removes the last note.
- clear_btn  input  1  level; its rising edge empties the composition.
- play_btn  input  1  level; its rising edge toggles between edit and play.
- note_RAM  output  6 x [MAX_NOTES-1:0]  unpacked note array, registered.
- i_note  output  IDX_W  number of notes placed, 0..MAX_NOTES, registered.
- write_en  output  1  high while in play state; gates the playback decoder.
- full  output  1  combinational, i_note == MAX_NOTES.

Behaviour:
- All buttons are already synchronised and debounced upstream.
- Edge detection:
  - Each button has a previous-sample register: prev <= btn every cycle; reset value 0.
  - rise = btn & ~prev, evaluated combinationally.
  - An action is taken at the same clock edge on which rise is 1, and is visible one cycle after the input first reads high.
  - Holding a button gives exactly one action.
- Reset, asynchronous: every note_RAM entry = 0, i_note = 0, state = S_EDIT, write_en = 0, all prev registers = 0.
- State machine, states S_EDIT and S_PLAY:
  - S_EDIT -> S_PLAY on play rise with i_note != 0. A play rise with i_note == 0 is ignored and the state stays S_EDIT.
  - S_PLAY -> S_EDIT on play rise.
  - write_en is registered and equals 1 exactly when state == S_PLAY. It rises one edge after the accepted play rise.
- Edit actions, taken only in S_EDIT:
  - Append: if !full, note_RAM[i_note] <= note_in and i_note <= i_note + 1. When full, the append is dropped with no change.
  - Undo: if i_note != 0, i_note <= i_note - 1 and note_RAM[i_note-1] <= 0. When i_note == 0, nothing happens.
  - Clear: i_note <= 0 and all entries <= 0.
- Simultaneous rises in the same cycle: priority is clear > undo > append, and only one edit action is performed per cycle.
- A play rise is independent of edit actions. If play and an edit rise coincide in S_EDIT, the edit is applied and the state still transitions, provided the pre-edit i_note != 0.
- In S_PLAY, add, undo and clear rises are ignored. note_RAM and i_note are frozen for the whole playback, so the decoder sees stable data.
- i_note never wraps: it saturates at MAX_NOTES on append and at 0 on undo.
- Entries at indices >= i_note are always 0, since undo and clear zero the slots they remove.
- Reset asserted mid-playback: write_en drops to 0 immediately (asynchronously) and the contents are lost.

Decomposition:
- Package composition_pkg holds:
  - localparam MAX_NOTES = 40, NOTE_W = 6, IDX_W = 6;
  - typedef note_t as logic [NOTE_W-1:0];
  - enum rec_state_t {S_EDIT, S_PLAY}.
- Sub-module rise_detect(clk, reset, in, rise) is instantiated four times, once per button.
- Top level contains the state register, the index/count logic and the array write logic.

Test Plan:
- Reset, then append notes 5, 17, 63 (one press each): i_note = 3, note_RAM[0..2] = 5, 17, 63, note_RAM[3] = 0, write_en = 0.
- Hold add_btn high for 10 cycles with note_in = 9 → exactly one append, i_note increments by 1.
- Perform 41 appends: i_note saturates at 40 and full = 1. An undo then gives i_note = 39, note_RAM[39] = 0, full = 0.
- Undo at i_note = 0 → no change. Raise clear and add in the same cycle with i_note = 4 → i_note = 0 and every entry = 0.
- Play press at i_note = 0 → write_en stays 0. Append 12, press play → write_en = 1 one cycle later. Add/undo/clear presses during play leave i_note = 1 and note_RAM[0] = 12. A second play press → write_en = 0.
- Assert reset during S_PLAY with i_note = 3 → write_en = 0 without waiting for a clock edge, i_note = 0, state S_EDIT after release.
